// File: rtl/jtframe_bank_arb.sv
// jtframe_bank_arb
// Round-robin arbiter that shares one SDRAM bank port between NREQ
// game-side requesters. Only one transaction is outstanding at a time.
// Read data and a one-cycle completion pulse go back to the granted
// requester only.
//
// Optional build macro: JTFRAME_BANK_ARB_FIXPRIO_EN
//   defined   -> requester 0 has absolute priority and a requester-0
//                grant leaves the round-robin pointer untouched;
//                requesters 1..NREQ-1 rotate among themselves.
//   undefined -> pure round-robin over all requesters.

module jtframe_bank_arb #(
  parameter int NREQ = 4,   // number of requesters (2..8)
  parameter int AW   = 22,  // word address width
  parameter int DW   = 16   // data width
) (
  input  logic                clk,
  input  logic                rst_n,
  // game side
  input  logic [NREQ*AW-1:0]  req_addr,
  input  logic [NREQ-1:0]     req_rd,
  input  logic [NREQ-1:0]     req_wr,
  input  logic [NREQ*DW-1:0]  req_din,
  input  logic [NREQ*2-1:0]   req_dsn,
  output logic [NREQ-1:0]     req_ok,
  output logic [DW-1:0]       req_dout,
  // SDRAM bank side
  output logic [AW-1:0]       ba_addr,
  output logic                ba_rd,
  output logic                ba_wr,
  output logic [DW-1:0]       ba_din,
  output logic [1:0]          ba_dsn,
  input  logic                ba_ack,
  input  logic                ba_dst,
  input  logic                ba_rdy,
  input  logic [DW-1:0]       sdram_dout,
  // status
  output logic                busy
);

  localparam int IW = $clog2(NREQ);
  localparam int SW = IW + 1;
  localparam logic [SW-1:0] NREQ_S = SW'(NREQ);
  localparam logic [IW-1:0] LAST   = IW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state_q,    state_d;
  logic [IW-1:0]   g_q,        g_d;
  logic [IW-1:0]   rr_q,       rr_d;
  logic            is_rd_q,    is_rd_d;
  logic [AW-1:0]   ba_addr_q,  ba_addr_d;
  logic [DW-1:0]   ba_din_q,   ba_din_d;
  logic [1:0]      ba_dsn_q,   ba_dsn_d;
  logic            ba_rd_q,    ba_rd_d;
  logic            ba_wr_q,    ba_wr_d;
  logic            busy_q,     busy_d;
  logic [NREQ-1:0] req_ok_q,   req_ok_d;
  logic [DW-1:0]   req_dout_q, req_dout_d;

  // per-requester views of the packed buses
  logic [AW-1:0]   addr_a [NREQ];
  logic [DW-1:0]   din_a  [NREQ];
  logic [1:0]      dsn_a  [NREQ];

  // arbitration
  logic [NREQ-1:0] pend;
  logic [NREQ-1:0] scan;
  logic [SW-1:0]   slot;
  logic [IW-1:0]   pick;
  logic            pick_vld;

  // ba_dst carries no control meaning for this arbiter
  logic unused_dst;
  assign unused_dst = ba_dst;

  // split the packed request buses into per-requester arrays
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_a[i] = req_addr[i*AW +: AW];
      din_a[i]  = req_din[i*DW +: DW];
      dsn_a[i]  = req_dsn[i*2 +: 2];
    end
  end

  // pick the first pending requester scanning rr, rr+1, ... with wrap
  always_comb begin
    pend = req_rd | req_wr;
    scan = pend;
`ifdef JTFRAME_BANK_ARB_FIXPRIO_EN
    // requester 0 is handled outside the rotation
    scan[0] = 1'b0;
`endif
    pick     = '0;
    pick_vld = 1'b0;
    slot     = '0;
    // walk from the farthest slot back to rr so the nearest pending one wins;
    // the wrap is an explicit compare so non-power-of-two NREQ works
    for (int k = NREQ - 1; k >= 0; k--) begin
      slot = {1'b0, rr_q} + SW'(k);
      if (slot >= NREQ_S) slot = slot - NREQ_S;
      if (scan[slot[IW-1:0]]) begin
        pick     = slot[IW-1:0];
        pick_vld = 1'b1;
      end
    end
`ifdef JTFRAME_BANK_ARB_FIXPRIO_EN
    if (pend[0]) begin
      pick     = '0;
      pick_vld = 1'b1;
    end
`endif
  end

  // next-state and datapath for the transaction FSM
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned; a missing default in always_comb infers a latch.
    state_d    = state_q;
    g_d        = g_q;
    rr_d       = rr_q;
    is_rd_d    = is_rd_q;
    ba_addr_d  = ba_addr_q;
    ba_din_d   = ba_din_q;
    ba_dsn_d   = ba_dsn_q;
    ba_rd_d    = ba_rd_q;
    ba_wr_d    = ba_wr_q;
    busy_d     = busy_q;
    req_ok_d   = '0;
    req_dout_d = req_dout_q;

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          g_d       = pick;
          ba_addr_d = addr_a[pick];
          ba_din_d  = din_a[pick];
          ba_dsn_d  = dsn_a[pick];
          // read wins when a requester raises both strobes
          is_rd_d   = req_rd[pick];
          ba_rd_d   = req_rd[pick];
          ba_wr_d   = req_wr[pick] & ~req_rd[pick];
          busy_d    = 1'b1;
          state_d   = S_REQ;
        end
      end

      S_REQ: begin
        if (ba_ack) begin
          ba_rd_d = 1'b0;
          ba_wr_d = 1'b0;
          if (ba_rdy) begin
            // controller finished in the ack cycle: skip WAIT
            if (is_rd_q) req_dout_d = sdram_dout;
            req_ok_d[g_q] = 1'b1;
            state_d       = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (ba_rdy) begin
          if (is_rd_q) req_dout_d = sdram_dout;
          req_ok_d[g_q] = 1'b1;
          state_d       = S_DONE;
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
`ifdef JTFRAME_BANK_ARB_FIXPRIO_EN
        if (g_q != '0) rr_d = (g_q == LAST) ? '0 : g_q + IW'(1);
`else
        rr_d = (g_q == LAST) ? '0 : g_q + IW'(1);
`endif
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      g_q        <= '0;
      rr_q       <= '0;
      is_rd_q    <= 1'b0;
      ba_addr_q  <= '0;
      ba_din_q   <= '0;
      ba_dsn_q   <= 2'b11;
      ba_rd_q    <= 1'b0;
      ba_wr_q    <= 1'b0;
      busy_q     <= 1'b0;
      req_ok_q   <= '0;
      req_dout_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      g_q        <= g_d;
      rr_q       <= rr_d;
      is_rd_q    <= is_rd_d;
      ba_addr_q  <= ba_addr_d;
      ba_din_q   <= ba_din_d;
      ba_dsn_q   <= ba_dsn_d;
      ba_rd_q    <= ba_rd_d;
      ba_wr_q    <= ba_wr_d;
      busy_q     <= busy_d;
      req_ok_q   <= req_ok_d;
      req_dout_q <= req_dout_d;
    end
  end

  assign ba_addr  = ba_addr_q;
  assign ba_din   = ba_din_q;
  assign ba_dsn   = ba_dsn_q;
  assign ba_rd    = ba_rd_q;
  assign ba_wr    = ba_wr_q;
  assign busy     = busy_q;
  assign req_ok   = req_ok_q;
  assign req_dout = req_dout_q;

endmodule

// File: tb/tb_jtframe_bank_arb.sv
// Testbench for jtframe_bank_arb: directed scenarios followed by random
// traffic, all checked against a transaction-level reference model.
`timescale 1ns/1ps

module tb_jtframe_bank_arb;

  localparam int NREQ = 4;
  localparam int AW   = 22;
  localparam int DW   = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ-1:0]     req_rd, req_wr, req_ok;
  logic [NREQ*DW-1:0]  req_din;
  logic [NREQ*2-1:0]   req_dsn;
  logic [DW-1:0]       req_dout, ba_din, sdram_dout;
  logic [AW-1:0]       ba_addr;
  logic                ba_rd, ba_wr, busy;
  logic [1:0]          ba_dsn;
  logic                ba_ack = 1'b0, ba_dst = 1'b0, ba_rdy = 1'b0;

  jtframe_bank_arb #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_addr(req_addr), .req_rd(req_rd), .req_wr(req_wr),
    .req_din(req_din), .req_dsn(req_dsn),
    .req_ok(req_ok), .req_dout(req_dout),
    .ba_addr(ba_addr), .ba_rd(ba_rd), .ba_wr(ba_wr),
    .ba_din(ba_din), .ba_dsn(ba_dsn),
    .ba_ack(ba_ack), .ba_dst(ba_dst), .ba_rdy(ba_rdy),
    .sdram_dout(sdram_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  // live requester values
  logic [AW-1:0] a_addr [NREQ];
  logic [DW-1:0] a_din  [NREQ];
  logic [1:0]    a_dsn  [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW] = a_addr[i];
      req_din[i*DW +: DW]  = a_din[i];
      req_dsn[i*2 +: 2]    = a_dsn[i];
    end
  end

  // values presented to the DUT at the upcoming edge
  logic [NREQ-1:0] p_rd, p_wr;
  logic [AW-1:0]   p_addr [NREQ];
  logic [DW-1:0]   p_din  [NREQ];
  logic [1:0]      p_dsn  [NREQ];

  // reference model: phase 0 idle, 1 strobing, 2 acked, 3 completed
  int            m_rr, m_phase, m_g;
  bit            m_rd, m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din, m_dout, m_data;
  logic [1:0]    m_dsn;
  int            ack_cnt, rdy_cnt, done_cnt;
  bit            drove_ack, drove_rdy;
  int            wait_cnt [NREQ];
  int            grants [$];

  // scenario configuration
  int              cfg_ack, cfg_rdy;
  bit              cfg_rand_dly, cfg_rand_req, cfg_data_en;
  logic [DW-1:0]   cfg_data;
  logic [NREQ-1:0] cont_mask;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // round-robin choice from the rules: scan rr, rr+1, ... modulo NREQ
  function automatic int arb(input logic [NREQ-1:0] p, input int rr);
`ifdef JTFRAME_BANK_ARB_FIXPRIO_EN
    if (p[0]) return 0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (rr + k) % NREQ;
`ifdef JTFRAME_BANK_ARB_FIXPRIO_EN
      if (i != 0 && p[i]) return i;
`else
      if (p[i]) return i;
`endif
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input bit rd, input bit wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [1:0] m);
    req_rd[i] = rd;
    req_wr[i] = wr;
    a_addr[i] = a;
    a_din[i]  = d;
    a_dsn[i]  = m;
  endtask

  // one clock cycle: check what the DUT shows, then drive the next inputs
  task automatic step();
    logic [NREQ-1:0] pp, exp_ok;
    int g;
    p_rd = req_rd;
    p_wr = req_wr;
    for (int i = 0; i < NREQ; i++) begin
      p_addr[i] = a_addr[i];
      p_din[i]  = a_din[i];
      p_dsn[i]  = a_dsn[i];
    end
    @(posedge clk);
    #1;
    pp = p_rd | p_wr;

    if (m_phase == 0) begin
      if (pp != '0) begin
        g      = arb(pp, m_rr);
        m_g    = g;
        m_rd   = p_rd[g];
        m_wr   = p_wr[g] & ~p_rd[g];
        m_addr = p_addr[g];
        m_din  = p_din[g];
        m_dsn  = p_dsn[g];
        check("grant_busy", busy, 1);
        check("grant_rd", ba_rd, m_rd);
        check("grant_wr", ba_wr, m_wr);
        check("grant_addr", ba_addr, m_addr);
        check("grant_din", ba_din, m_din);
        check("grant_dsn", ba_dsn, m_dsn);
`ifndef JTFRAME_BANK_ARB_FIXPRIO_EN
        check("starve", wait_cnt[g] <= NREQ - 1, 1);
        for (int i = 0; i < NREQ; i++)
          wait_cnt[i] = (i != g && pp[i]) ? wait_cnt[i] + 1 : 0;
`endif
        m_phase = 1;
        ack_cnt = cfg_rand_dly ? int'($urandom_range(0, 3)) : cfg_ack;
        rdy_cnt = 0;
      end else begin
        check("idle_busy", busy, 0);
        check("idle_strobe", {ba_rd, ba_wr}, 0);
      end
    end else if (m_phase == 1) begin
      check("hold_busy", busy, 1);
      if (drove_ack) begin
        check("ack_drop", {ba_rd, ba_wr}, 0);
        m_phase = 2;
      end else begin
        check("hold_rd", ba_rd, m_rd);
        check("hold_wr", ba_wr, m_wr);
        check("hold_addr", ba_addr, m_addr);
        check("hold_din", ba_din, m_din);
        check("hold_dsn", ba_dsn, m_dsn);
      end
    end else if (m_phase == 2) begin
      check("wait_busy", busy, 1);
      check("wait_strobe", {ba_rd, ba_wr}, 0);
    end else if (m_phase == 3) begin
      check("done_release", busy, 0);
      m_phase = 0;
    end

    exp_ok = '0;
    if (drove_rdy) begin
      exp_ok[m_g] = 1'b1;
      if (m_rd) m_dout = m_data;
      check("done_busy", busy, 1);
`ifdef JTFRAME_BANK_ARB_FIXPRIO_EN
      if (m_g != 0) m_rr = (m_g + 1) % NREQ;
`else
      m_rr = (m_g + 1) % NREQ;
`endif
      done_cnt++;
      grants.push_back(m_g);
      m_phase = 3;
      if (!cont_mask[m_g]) begin
        req_rd[m_g] = 1'b0;
        req_wr[m_g] = 1'b0;
      end
    end
    check("req_ok", req_ok, exp_ok);
    check("req_dout", req_dout, m_dout);

    // controller model
    ba_ack     = 1'b0;
    ba_rdy     = 1'b0;
    ba_dst     = 1'($urandom);
    sdram_dout = DW'($urandom);
    if (m_phase == 1) begin
      if (ack_cnt == 0) begin
        ba_ack  = 1'b1;
        rdy_cnt = cfg_rand_dly ? int'($urandom_range(0, 4)) : cfg_rdy;
        if (rdy_cnt == 0) ba_rdy = 1'b1;
      end else begin
        ack_cnt--;
      end
    end else if (m_phase == 2) begin
      rdy_cnt--;
      if (rdy_cnt == 0) ba_rdy = 1'b1;
    end
    if (ba_rdy) begin
      if (cfg_data_en) sdram_dout = cfg_data;
      m_data = sdram_dout;
    end
    drove_ack = ba_ack;
    drove_rdy = ba_rdy;

    // random requester traffic
    if (cfg_rand_req) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!(req_rd[i] | req_wr[i])) begin
          if ($urandom_range(0, 3) == 0) begin
            int r;
            r = int'($urandom_range(0, 2));
            set_req(i, r != 1, r != 0, AW'($urandom), DW'($urandom), 2'($urandom));
          end
        end else if (m_phase != 0 && i == m_g && $urandom_range(0, 15) == 0) begin
          req_rd[i] = 1'b0;
          req_wr[i] = 1'b0;
        end else if ($urandom_range(0, 7) == 0) begin
          a_addr[i] = AW'($urandom);
          a_din[i]  = DW'($urandom);
        end
      end
    end
  endtask

  task automatic run_txns(input int n);
    int target, cyc;
    target = done_cnt + n;
    cyc    = 0;
    while (done_cnt < target && cyc < 40 * n + 40) begin
      step();
      cyc++;
    end
    if (done_cnt < target) check("timeout", done_cnt, target);
  endtask

  task automatic drain();
    int cyc;
    cont_mask    = '0;
    cfg_rand_req = 1'b0;
    req_rd       = '0;
    req_wr       = '0;
    cyc          = 0;
    while (m_phase != 0 && cyc < 60) begin
      step();
      cyc++;
    end
    if (m_phase != 0) check("drain_timeout", m_phase, 0);
    step();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_rd", ba_rd, 0);
    check("rst_wr", ba_wr, 0);
    check("rst_busy", busy, 0);
    check("rst_ok", req_ok, 0);
    check("rst_addr", ba_addr, 0);
    check("rst_din", ba_din, 0);
    check("rst_dsn", ba_dsn, 2'b11);
    check("rst_dout", req_dout, 0);
    m_rr      = 0;
    m_phase   = 0;
    m_dout    = '0;
    drove_ack = 1'b0;
    drove_rdy = 1'b0;
    ba_ack    = 1'b0;
    ba_rdy    = 1'b0;
    for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int cyc;
    req_rd = '0;
    req_wr = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1'b0, '0, '0, 2'b11);
    sdram_dout   = '0;
    done_cnt     = 0;
    cfg_ack      = 0;
    cfg_rdy      = 1;
    cfg_rand_dly = 1'b0;
    cfg_rand_req = 1'b0;
    cfg_data_en  = 1'b1;
    cfg_data     = '0;
    cont_mask    = '0;
    m_data       = '0;

    do_reset();
    repeat (3) step();

    // single read from requester 2: ack in cycle 3, rdy in cycle 6
    set_req(2, 1'b1, 1'b0, 22'h12345, 16'h0000, 2'b00);
    cfg_ack  = 2;
    cfg_rdy  = 3;
    cfg_data = 16'hBEEF;
    run_txns(1);
    check("read_dout", req_dout, 16'hBEEF);
    check("read_grant", grants[grants.size() - 1], 2);
    step();

    // single write from requester 1
    set_req(1, 1'b0, 1'b1, 22'h2ABCD, 16'hA5A5, 2'b10);
    cfg_ack = 1;
    cfg_rdy = 2;
    run_txns(1);
    check("write_keeps_dout", req_dout, 16'hBEEF);
    step();

    // ack and rdy in the same cycle
    set_req(0, 1'b1, 1'b0, 22'h00777, 16'h0000, 2'b01);
    cfg_ack  = 0;
    cfg_rdy  = 0;
    cfg_data = 16'h1234;
    run_txns(1);
    check("same_cycle_dout", req_dout, 16'h1234);
    step();

    // all requesters reading continuously, one-cycle ack/rdy
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, AW'(22'h100 * (i + 1)), '0, 2'b00);
    cont_mask = '1;
    cfg_rdy   = 1;
    grants.delete();
    run_txns(12);
`ifndef JTFRAME_BANK_ARB_FIXPRIO_EN
    for (int k = 1; k < grants.size(); k++)
      check("rr_order", grants[k], (grants[k-1] + 1) % NREQ);
`endif
    drain();

    // reset while waiting for rdy, requester 3 pending afterwards
    set_req(1, 1'b1, 1'b0, 22'h3C3C3, '0, 2'b00);
    cfg_ack = 0;
    cfg_rdy = 6;
    cyc = 0;
    while (m_phase != 2 && cyc < 20) begin
      step();
      cyc++;
    end
    check("reach_wait", m_phase, 2);
    req_rd[1] = 1'b0;
    set_req(3, 1'b1, 1'b0, 22'h0F0F0, '0, 2'b00);
    cfg_rdy = 1;
    grants.delete();
    do_reset();
    run_txns(1);
    check("reset_grant", grants.size() > 0 ? grants[0] : -1, 3);
    step();

    // requesters 0 and 2 continuously requesting
    set_req(0, 1'b1, 1'b0, 22'h00AAA, '0, 2'b00);
    set_req(2, 1'b1, 1'b0, 22'h00BBB, '0, 2'b00);
    cont_mask = 4'b0101;
    grants.delete();
    run_txns(8);
    for (int k = 1; k < grants.size(); k++) begin
`ifdef JTFRAME_BANK_ARB_FIXPRIO_EN
      check("fixprio_grant", grants[k], 0);
`else
      check("alt_grant", grants[k] != grants[k-1], 1);
`endif
    end
    drain();

    // random traffic and random controller latency
    cfg_data_en  = 1'b0;
    cfg_rand_dly = 1'b1;
    cfg_rand_req = 1'b1;
    run_txns(300);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jtframe_bank_arb.md
Name: jtframe_bank_arb

Overview:
- Shares one SDRAM bank port (addr/rd/wr/din/dsn with ack/dst/rdy handshake) between NREQ game-side requesters.
- Sits between game logic and the bank-0 port of the SDRAM controller inside the frame top.
- Grants one transaction at a time using round-robin priority.
- Returns read data and a completion strobe to the granted requester only.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 22, address width; matches SDRAMW.
- DW, 16, data width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_addr  in  NREQ*AW  packed word addresses; requester i uses slice [i*AW +: AW].
- req_rd  in  NREQ  per-requester read request; level, held until its req_ok.
- req_wr  in  NREQ  per-requester write request; level, held until its req_ok.
- req_din  in  NREQ*DW  packed write data.
- req_dsn  in  NREQ*2  packed byte-enable-n.
- req_ok  out  NREQ  one-cycle completion pulse, one-hot.
- req_dout  out  DW  data from the last completed read; holds its value until the next read completes.
- ba_addr  out  AW  bank address.
- ba_rd  out  1  bank read strobe.
- ba_wr  out  1  bank write strobe.
- ba_din  out  DW  bank write data.
- ba_dsn  out  2  bank byte mask.
- ba_ack  in  1  controller accepted the request.
- ba_dst  in  1  data start; first data cycle.
- ba_rdy  in  1  transfer complete; read data valid on sdram_dout.
- sdram_dout  in  DW  controller read data.
- busy  out  1  high while a transaction is outstanding.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE.
  - ba_rd, ba_wr, req_ok, busy = 0.
  - ba_addr, ba_din, req_dout = 0; ba_dsn = 2'b11.
  - Round-robin pointer rr = 0.
- State IDLE:
  - Let pend[i] = req_rd[i] | req_wr[i].
  - If any pend bit is set, select the first set index scanning rr, rr+1, …, NREQ-1, 0, …, rr-1. Call it g.
  - Register g, and latch ba_addr, ba_din and ba_dsn from slice g.
  - ba_rd = req_rd[g]; ba_wr = req_wr[g] & ~req_rd[g] (read wins if both are set).
  - busy = 1. Go to REQ.
  - Latency: request visible in cycle N appears on ba_* in cycle N+1.
- State REQ:
  - Hold ba_rd/ba_wr and ba_addr/ba_din/ba_dsn until ba_ack = 1.
  - On ack, drop ba_rd/ba_wr in the next cycle. Go to WAIT.
  - If ba_rdy arrives in the same cycle as ba_ack, treat it as completion and go directly to DONE.
- State WAIT:
  - Wait for ba_rdy. ba_dst is ignored for control.
  - On ba_rdy for a read, latch sdram_dout into req_dout. Go to DONE.
- State DONE (1 cycle):
  - req_ok[g] = 1; all other req_ok bits = 0.
  - rr = (g+1) mod NREQ. busy = 0 at the end of this cycle. Go to IDLE.
  - The requester must drop its request in the cycle after req_ok; IDLE samples the next cycle, so there is no double grant.
  - Minimum transaction is 4 cycles: IDLE → REQ → WAIT/DONE → IDLE.
- Requester withdraws mid-transaction: the transaction still completes and req_ok[g] still pulses. The latched address and data are used, not the live inputs.
- Inputs are sampled only in IDLE. Changes to unselected requesters during a transaction take no effect until the next IDLE.
- No requests: stays in IDLE with all strobes low.
- Reset asserted mid-transaction: immediate return to reset values. The controller side must tolerate an abandoned strobe; no req_ok is issued.
- NREQ not a power of two: the rr wrap uses an explicit compare, not bit truncation.

Optional Feature:
- Macro JTFRAME_BANK_ARB_FIXPRIO_EN.
- Defined: requester 0 has absolute priority. If req_rd[0] | req_wr[0] is set in IDLE, it is granted regardless of rr, and rr is not updated after a requester-0 grant. Requesters 1..NREQ-1 stay round-robin among themselves.
- Undefined: pure round-robin as above.

Test Plan:
- Single read, requester 2: addr 0x12345; ba_ack at cycle 3, ba_rdy at cycle 6, sdram_dout = 0xBEEF → ba_addr = 0x12345 and ba_rd = 1 from cycle 1 to the ack cycle; req_ok = 4'b0100 for one cycle; req_dout = 0xBEEF.
- Single write, requester 1: din 0xA5A5, dsn 2'b10 → ba_wr = 1 and ba_din = 0xA5A5 with ba_dsn = 2'b10 until ack; ba_rd stays 0; req_ok[1] pulses.
- All four requesters reading continuously, one-cycle ack/rdy model → grant order 0,1,2,3,0,1,…; no requester waits more than 3 transactions.
- ba_ack and ba_rdy in the same cycle → WAIT is skipped; req_ok pulses in the next cycle with the correct req_dout.
- rst_n pulled low while in WAIT → all outputs at reset values asynchronously; after release with requester 3 pending, it is granted with rr = 0 scan order.
- With JTFRAME_BANK_ARB_FIXPRIO_EN, requesters 0 and 2 continuously requesting → requester 0 is always granted while requesting; without the macro, grants alternate 0,2,0,2.
